// File: rtl/calc_pkg.sv
// Shared calculator definitions: datapath width and divider state codes.
package calc_pkg;

  localparam int CALC_W = 4;

  typedef enum logic [2:0] {
    DIV_IDLE  = 3'd0,
    DIV_LOAD  = 3'd1,
    DIV_STEP  = 3'd2,
    DIV_DONE  = 3'd3,
    DIV_ERROR = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division bit: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_W
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nx,
  output logic             q_bit
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] diff;

  assign t    = {rem, dvd_msb};
  assign diff = t - {1'b0, dvs};

  // rem < dvs always holds, so t < 2*dvs and the top bit of diff is exactly the borrow.
  assign q_bit  = ~diff[WIDTH];
  assign rem_nx = q_bit ? diff[WIDTH-1:0] : t[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, MSB first,
// with one-cycle Done/Err strobes decoded from the FSM state.
module div_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Go,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             Done,
  output logic             Err,
  output logic [2:0]       CS
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] dvd, dvs;
  // The partial remainder is always below the divisor, so WIDTH bits hold it.
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] rem_nx;
  logic             q_bit;
  logic [WIDTH-1:0] dvd_nx;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .dvd_msb (dvd[WIDTH-1]),
    .dvs     (dvs),
    .rem_nx  (rem_nx),
    .q_bit   (q_bit)
  );

  assign dvd_nx = {dvd[WIDTH-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = DIV_IDLE;
    case (state_q)
      DIV_IDLE:  state_d = Go ? DIV_LOAD : DIV_IDLE;
      DIV_LOAD:  state_d = (dvs == '0) ? DIV_ERROR : DIV_STEP;
      DIV_STEP:  state_d = (cnt == CNT_W'(1)) ? DIV_DONE : DIV_STEP;
      DIV_DONE:  state_d = DIV_IDLE;
      DIV_ERROR: state_d = DIV_IDLE;
      default:   state_d = DIV_IDLE;
    endcase
  end

  // Q/R change only on entry to DONE or ERROR, so they are valid while the strobe is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
      Q   <= '0;
      R   <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (Go) begin
            dvd <= X;
            dvs <= Y;
            rem <= '0;
            cnt <= CNT_W'(WIDTH);
          end
        end
        DIV_LOAD: begin
          if (dvs == '0) begin
            Q <= '0;
            R <= '0;
          end
        end
        DIV_STEP: begin
          rem <= rem_nx;
          dvd <= dvd_nx;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            Q <= dvd_nx;
            R <= rem_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign Done = (state_q == DIV_DONE);
  assign Err  = (state_q == DIV_ERROR);
  assign CS   = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected quotient/remainder
// pushed at Go and popped when Done/Err appears.
module tb_div_unit;
  import calc_pkg::*;

  localparam int W = CALC_W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         Go  = 1'b0;
  logic [W-1:0] X   = '0;
  logic [W-1:0] Y   = '0;
  logic [W-1:0] Q, R;
  logic         Done, Err;
  logic [2:0]   CS;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  int   err_cnt  = 0;
  int   both_cnt = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .Go   (Go),
    .X    (X),
    .Y    (Y),
    .Q    (Q),
    .R    (R),
    .Done (Done),
    .Err  (Err),
    .CS   (CS)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Done) done_cnt++;
    if (Err) err_cnt++;
    if (Done && Err) both_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    if (y == '0) begin
      e.q = '0; e.r = '0; e.err = 1'b1;
    end else begin
      e.q = W'(int'(x) / int'(y));
      e.r = W'(int'(x) % int'(y));
      e.err = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Single Go pulse, wait (bounded) for the strobe, compare against the scoreboard.
  task automatic do_div(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   cyc;
    int   lat;
    lat = (y == '0) ? 2 : W + 2;
    push_exp(x, y);
    X = x; Y = y; Go = 1'b1;
    tick();
    Go = 1'b0;
    cyc = 1;
    while (!(Done || Err) && cyc < 30) begin
      tick();
      cyc++;
    end
    e = sb.pop_front();
    n_checks++;
    if (cyc !== lat) $display("FAIL latency %0d/%0d: got %0d cycles, want %0d", x, y, cyc, lat);
    else n_pass++;
    n_checks++;
    if (Done !== !e.err || Err !== e.err)
      $display("FAIL strobe %0d/%0d: Done=%b Err=%b, want Done=%b Err=%b", x, y, Done, Err, !e.err, e.err);
    else n_pass++;
    n_checks++;
    if (Q !== e.q || R !== e.r)
      $display("FAIL result %0d/%0d: Q=%0d R=%0d, want Q=%0d R=%0d", x, y, Q, R, e.q, e.r);
    else n_pass++;
    tick();
    n_checks++;
    if (Done !== 1'b0 || Err !== 1'b0 || CS !== 3'(DIV_IDLE))
      $display("FAIL after_strobe %0d/%0d: Done=%b Err=%b CS=%0d, want 0 0 0", x, y, Done, Err, CS);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (CS !== 3'd0 || Q !== '0 || R !== '0 || Done !== 1'b0 || Err !== 1'b0)
      $display("FAIL reset: CS=%0d Q=%0d R=%0d Done=%b Err=%b, want all 0", CS, Q, R, Done, Err);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [2:0] seen [8];
    logic [2:0] want [8];
    int         done_at = -1;
    int         n_done  = 0;
    logic       err_seen = 1'b0;
    exp_t       e;
    want = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd0};
    push_exp(4'd13, 4'd4);
    X = 4'd13; Y = 4'd4; Go = 1'b1;
    seen[0] = CS;
    tick();
    Go = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      seen[c] = CS;
      if (Err) err_seen = 1'b1;
      if (Done) begin
        done_at = c;
        n_done++;
        e = sb.pop_front();
        n_checks++;
        if (Q !== e.q || R !== e.r)
          $display("FAIL basic_result: Q=%0d R=%0d, want Q=%0d R=%0d", Q, R, e.q, e.r);
        else n_pass++;
      end
      if (c < 7) tick();
    end
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if (seen[c] !== want[c]) $display("FAIL basic_cs[%0d]: CS=%0d, want %0d", c, seen[c], want[c]);
      else n_pass++;
    end
    n_checks++;
    if (done_at !== 6 || n_done !== 1 || err_seen !== 1'b0)
      $display("FAIL basic_strobes: done_at=%0d n_done=%0d err=%b, want 6 1 0", done_at, n_done, err_seen);
    else n_pass++;
    tick();
  endtask

  task automatic test_patterns();
    do_div(4'd15, 4'd1);
    do_div(4'd3, 4'd7);
    do_div(4'd0, 4'd5);
    do_div(4'd15, 4'd15);
    do_div(4'd14, 4'd5);
  endtask

  task automatic test_div_zero();
    int d0, e0;
    do_div(4'd13, 4'd4);
    d0 = done_cnt; e0 = err_cnt;
    do_div(4'd5, 4'd0);
    n_checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1)
      $display("FAIL div_zero_counts: done=%0d err=%0d, want 0 1", done_cnt - d0, err_cnt - e0);
    else n_pass++;
  endtask

  task automatic test_ignore_go();
    int   d0;
    int   cyc;
    exp_t e;
    d0 = done_cnt;
    push_exp(4'd13, 4'd4);
    X = 4'd13; Y = 4'd4; Go = 1'b1;
    tick();
    Go = 1'b0;
    tick();
    tick();
    X = 4'd9; Y = 4'd2; Go = 1'b1;
    tick();
    Go = 1'b0; X = 4'd6; Y = 4'd0;
    tick();
    X = 4'd15; Y = 4'd1;
    cyc = 5;
    while (!Done && cyc < 30) begin
      tick();
      cyc++;
    end
    e = sb.pop_front();
    n_checks++;
    if (Done !== 1'b1 || Q !== e.q || R !== e.r)
      $display("FAIL ignore_go_result: Done=%b Q=%0d R=%0d, want 1 %0d %0d", Done, Q, R, e.q, e.r);
    else n_pass++;
    repeat (10) tick();
    n_checks++;
    if (done_cnt - d0 !== 1) $display("FAIL ignore_go_count: got %0d Done pulses, want 1", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    X = 4'd13; Y = 4'd4; Go = 1'b1;
    tick();
    Go = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (CS !== 3'd0 || Q !== '0 || R !== '0)
      $display("FAIL reset_midop: CS=%0d Q=%0d R=%0d, want 0 0 0", CS, Q, R);
    else n_pass++;
    repeat (8) tick();
    n_checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0)
      $display("FAIL reset_midop_strobes: done=%0d err=%0d, want 0 0", done_cnt - d0, err_cnt - e0);
    else n_pass++;
    do_div(4'd9, 4'd2);
  endtask

  task automatic test_go_held();
    exp_t e;
    int   last_done = -1;
    int   n_done = 0;
    X = 4'd14; Y = 4'd3; Go = 1'b1;
    push_exp(X, Y);
    tick();
    for (int c = 1; c <= 20; c++) begin
      if (c == 20) Go = 1'b0;
      if (Done) begin
        n_done++;
        n_checks++;
        if ((last_done < 0 && c !== 6) || (last_done >= 0 && c - last_done !== 7))
          $display("FAIL go_held_spacing: Done at cycle %0d, previous %0d", c, last_done);
        else n_pass++;
        last_done = c;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_checks++;
          if (Q !== e.q || R !== e.r)
            $display("FAIL go_held_result: Q=%0d R=%0d, want Q=%0d R=%0d", Q, R, e.q, e.r);
          else n_pass++;
        end
      end
      if (CS == 3'(DIV_IDLE) && Go) push_exp(X, Y);
      if (c < 20) tick();
    end
    n_checks++;
    if (n_done !== 3 || sb.size() !== 0)
      $display("FAIL go_held_count: got %0d Done pulses with %0d pending, want 3 and 0", n_done, sb.size());
    else n_pass++;
    Go = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_div_zero();
    test_ignore_go();
    test_reset_midop();
    test_go_held();
    n_checks++;
    if (both_cnt !== 0) $display("FAIL done_err_overlap: %0d cycles with both high, want 0", both_cnt);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
